// File: rtl/mhsa_bank_arbiter_if.sv
// SoC-side access bus of the MHSA bank arbiter: request/grant handshake,
// tagged read return, error pulse and stall counter.
interface mhsa_bank_arbiter_if #(
   parameter int unsigned WIDTH = 64
);
   logic             req;
   logic             write_en;
   logic [31:0]      addr;
   logic [WIDTH-1:0] data_in;
   logic             gnt;
   logic             rvalid;
   logic [WIDTH-1:0] data_out;
   logic             err;
   logic [15:0]      stall_cnt;

   modport master (
      output req, write_en, addr, data_in,
      input  gnt, rvalid, data_out, err, stall_cnt
   );

   modport slave (
      input  req, write_en, addr, data_in,
      output gnt, rvalid, data_out, err, stall_cnt
   );
endinterface

// File: rtl/mhsa_bank_arbiter.sv
// Arbitrates NUM_BANKS single-port SRAM banks between the SoC bus and the
// MHSA accelerator, draining in-flight reads on every ownership handover.
module mhsa_bank_arbiter #(
   parameter int unsigned WIDTH      = 64,
   parameter int unsigned NUM_BANKS  = 4,
   parameter int unsigned BANK_DEPTH = 4096,
   parameter int unsigned RD_LATENCY = 1,
   localparam int unsigned AW = $clog2(BANK_DEPTH),
   localparam int unsigned BW = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       acc_req,
   output logic                       acc_gnt,
   input  logic [NUM_BANKS-1:0]       acc_we,
   input  logic [NUM_BANKS*AW-1:0]    acc_addr,
   input  logic [NUM_BANKS*WIDTH-1:0] acc_wdata,
   output logic [NUM_BANKS*WIDTH-1:0] acc_rdata,
   mhsa_bank_arbiter_if.slave         soc,
   output logic [NUM_BANKS-1:0]       bank_we,
   output logic [NUM_BANKS*AW-1:0]    bank_addr,
   output logic [NUM_BANKS*WIDTH-1:0] bank_wdata,
   input  logic [NUM_BANKS*WIDTH-1:0] bank_rdata
);

   localparam int unsigned SPAN = NUM_BANKS * BANK_DEPTH;
   localparam int unsigned TAIL = RD_LATENCY - 1;
   localparam int unsigned CW   = 3;

   typedef enum logic [1:0] {
      SOC_OWN,
      DRAIN_TO_ACC,
      ACC_OWN,
      DRAIN_TO_SOC
   } state_t;

   state_t state_q, state_d;
   logic [CW-1:0] drain_cnt_q, drain_cnt_d;

   logic [RD_LATENCY-1:0]         rd_vld_q;
   logic [RD_LATENCY-1:0][BW-1:0] rd_bank_q;
   logic [15:0]                   stall_q;
   logic                          err_q;
   logic                          acc_gnt_q;

   logic [NUM_BANKS-1:0][AW-1:0]    acc_addr_arr, bank_addr_arr;
   logic [NUM_BANKS-1:0][WIDTH-1:0] acc_wdata_arr, bank_wdata_arr, rdata_arr;

   logic          in_range;
   logic          soc_gnt_c;
   logic [BW-1:0] bank_sel;
   logic [AW-1:0] word_sel;
   logic          rd_push;

   assign acc_addr_arr  = acc_addr;
   assign acc_wdata_arr = acc_wdata;
   assign rdata_arr     = bank_rdata;
   assign bank_addr     = bank_addr_arr;
   assign bank_wdata    = bank_wdata_arr;

   assign in_range  = soc.addr < 32'(SPAN);
   assign bank_sel  = soc.addr[AW +: BW];
   assign word_sel  = soc.addr[AW-1:0];
   // Gated by rst_n so the banks see nothing while reset is held.
   assign soc_gnt_c = rst_n & soc.req & in_range & (state_q == SOC_OWN);
   assign rd_push   = soc_gnt_c & ~soc.write_en;

   assign soc.gnt       = soc_gnt_c;
   assign soc.rvalid    = rd_vld_q[TAIL];
   assign soc.data_out  = rd_vld_q[TAIL] ? rdata_arr[rd_bank_q[TAIL]] : '0;
   assign soc.err       = err_q;
   assign soc.stall_cnt = stall_q;
   assign acc_gnt       = acc_gnt_q;

   // State, read-return pipeline, stall counter and error pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= SOC_OWN;
         drain_cnt_q <= '0;
         rd_vld_q    <= '0;
         rd_bank_q   <= '0;
         stall_q     <= '0;
         err_q       <= 1'b0;
         acc_gnt_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         drain_cnt_q <= drain_cnt_d;
         rd_vld_q    <= RD_LATENCY'({rd_vld_q, rd_push});
         rd_bank_q   <= (RD_LATENCY*BW)'({rd_bank_q, bank_sel});
         if (soc.req && in_range && !soc_gnt_c && (stall_q != 16'hFFFF))
            stall_q <= stall_q + 16'd1;
         err_q       <= soc.req & ~in_range & (state_q == SOC_OWN);
         acc_gnt_q   <= (state_d == ACC_OWN);
      end
   end

   // Next state plus bank steering for the current owner.
   always_comb begin
      state_d        = state_q;
      drain_cnt_d    = '0;
      bank_we        = '0;
      bank_addr_arr  = '0;
      bank_wdata_arr = '0;
      acc_rdata      = '0;

      case (state_q)
         SOC_OWN: begin
            if (acc_req) state_d = DRAIN_TO_ACC;
            if (soc_gnt_c) begin
               bank_we[bank_sel]        = soc.write_en;
               bank_addr_arr[bank_sel]  = word_sel;
               bank_wdata_arr[bank_sel] = soc.data_in;
            end
         end
         DRAIN_TO_ACC: begin
            if (rd_vld_q == '0) state_d = ACC_OWN;
         end
         ACC_OWN: begin
            if (!acc_req) state_d = DRAIN_TO_SOC;
            bank_we        = acc_we;
            bank_addr_arr  = acc_addr_arr;
            bank_wdata_arr = acc_wdata_arr;
            acc_rdata      = bank_rdata;
         end
         DRAIN_TO_SOC: begin
            // Accelerator keeps the address mux so its last reads complete.
            if (drain_cnt_q == CW'(RD_LATENCY - 1)) state_d = SOC_OWN;
            else drain_cnt_d = drain_cnt_q + CW'(1);
            bank_addr_arr  = acc_addr_arr;
            bank_wdata_arr = acc_wdata_arr;
            acc_rdata      = bank_rdata;
         end
         default: state_d = SOC_OWN;
      endcase
   end

endmodule

// File: tb/tb_mhsa_bank_arbiter.sv
// Directed bench for mhsa_bank_arbiter: three instances with RD_LATENCY 1/2/3
// share stimulus, each backed by a behavioural SRAM model of matching latency.
module tb_mhsa_bank_arbiter;
   localparam int unsigned WIDTH = 64;
   localparam int unsigned NB    = 4;
   localparam int unsigned DEPTH = 4096;
   localparam int unsigned AW    = 12;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic               acc_req;
   logic [NB-1:0]      acc_we;
   logic [NB*AW-1:0]   acc_addr;
   logic [NB*WIDTH-1:0] acc_wdata;
   logic               soc_req, soc_we;
   logic [31:0]        soc_addr;
   logic [WIDTH-1:0]   soc_din;

   logic                acc_gnt_a   [3];
   logic [NB*WIDTH-1:0] acc_rdata_a [3];
   logic [NB-1:0]       bank_we_a   [3];
   logic [NB*AW-1:0]    bank_addr_a [3];
   logic [NB*WIDTH-1:0] bank_wdata_a[3];
   logic [NB*WIDTH-1:0] bank_rdata_a[3];
   logic                gnt_a[3], rvalid_a[3], err_a[3];
   logic [WIDTH-1:0]    dout_a [3];
   logic [15:0]         stall_a[3];

   for (genvar k = 0; k < 3; k++) begin : g_inst
      mhsa_bank_arbiter_if #(.WIDTH(WIDTH)) sif ();
      assign sif.req      = soc_req;
      assign sif.write_en = soc_we;
      assign sif.addr     = soc_addr;
      assign sif.data_in  = soc_din;
      assign gnt_a[k]     = sif.gnt;
      assign rvalid_a[k]  = sif.rvalid;
      assign dout_a[k]    = sif.data_out;
      assign err_a[k]     = sif.err;
      assign stall_a[k]   = sif.stall_cnt;

      mhsa_bank_arbiter #(
         .WIDTH(WIDTH), .NUM_BANKS(NB), .BANK_DEPTH(DEPTH), .RD_LATENCY(k + 1)
      ) u_dut (
         .clk       (clk),
         .rst_n     (rst_n),
         .acc_req   (acc_req),
         .acc_gnt   (acc_gnt_a[k]),
         .acc_we    (acc_we),
         .acc_addr  (acc_addr),
         .acc_wdata (acc_wdata),
         .acc_rdata (acc_rdata_a[k]),
         .soc       (sif),
         .bank_we   (bank_we_a[k]),
         .bank_addr (bank_addr_a[k]),
         .bank_wdata(bank_wdata_a[k]),
         .bank_rdata(bank_rdata_a[k])
      );

      logic [WIDTH-1:0]    mem   [NB][DEPTH];
      logic [NB*WIDTH-1:0] rpipe [k + 1];
      always @(posedge clk) begin
         for (int b = 0; b < NB; b++) begin
            if (bank_we_a[k][b])
               mem[b][bank_addr_a[k][b*AW +: AW]] <= bank_wdata_a[k][b*WIDTH +: WIDTH];
            rpipe[0][b*WIDTH +: WIDTH] <= mem[b][bank_addr_a[k][b*AW +: AW]];
         end
         for (int i = 1; i <= k; i++) rpipe[i] <= rpipe[i-1];
      end
      assign bank_rdata_a[k] = rpipe[k];
   end

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      soc_req   = 1'b0;
      soc_we    = 1'b0;
      soc_addr  = '0;
      soc_din   = '0;
      acc_req   = 1'b0;
      acc_we    = '0;
      acc_addr  = '0;
      acc_wdata = '0;
      repeat (2) next_cycle();
      rst_n = 1'b1;
   endtask

   logic [31:0] t2_addr [3] = '{32'h0000_0010, 32'h0000_2010, 32'h0000_3010};
   logic [63:0] t2_data [3] = '{64'hA0, 64'hA2, 64'hA3};
   int w;

   initial begin
      // Power-on reset values
      rst_n = 1'b0; soc_req = 1'b0; soc_we = 1'b0; soc_addr = '0; soc_din = '0;
      acc_req = 1'b0; acc_we = '0; acc_addr = '0; acc_wdata = '0;
      mid();
      check("rst_acc_gnt", 64'(acc_gnt_a[0]), 64'd0);
      check("rst_rvalid",  64'(rvalid_a[0]),  64'd0);
      check("rst_err",     64'(err_a[0]),     64'd0);
      check("rst_stall",   64'(stall_a[0]),   64'd0);
      check("rst_bank_we", 64'(bank_we_a[0]), 64'd0);
      check("rst_dout",    dout_a[0],         64'd0);

      // Write then read back 0x1005, RD_LATENCY=1
      do_reset();
      soc_req = 1'b1; soc_we = 1'b1; soc_addr = 32'h1005; soc_din = 64'hDEAD_BEEF;
      mid();
      check("t1_wr_gnt",   64'(gnt_a[0]), 64'd1);
      check("t1_wr_we",    64'(bank_we_a[0]), 64'b0010);
      check("t1_wr_addr",  64'(bank_addr_a[0][AW +: AW]), 64'h005);
      check("t1_wr_data",  bank_wdata_a[0][WIDTH +: WIDTH], 64'hDEAD_BEEF);
      check("t1_wr_addr0", 64'(bank_addr_a[0][0 +: AW]), 64'h0);
      next_cycle();
      soc_we = 1'b0;
      mid();
      check("t1_rd_gnt",    64'(gnt_a[0]), 64'd1);
      check("t1_rd_rvalid", 64'(rvalid_a[0]), 64'd0);
      check("t1_rd_we",     64'(bank_we_a[0]), 64'd0);
      next_cycle();
      soc_req = 1'b0;
      mid();
      check("t1_rvalid", 64'(rvalid_a[0]), 64'd1);
      check("t1_rdata",  dout_a[0], 64'hDEAD_BEEF);
      next_cycle();
      mid();
      check("t1_rvalid_end", 64'(rvalid_a[0]), 64'd0);

      // Back-to-back reads across banks 0/2/3, RD_LATENCY=3
      do_reset();
      for (int i = 0; i < 3; i++) begin
         soc_req = 1'b1; soc_we = 1'b1; soc_addr = t2_addr[i]; soc_din = t2_data[i];
         next_cycle();
      end
      for (int i = 0; i < 3; i++) begin
         soc_we = 1'b0; soc_addr = t2_addr[i];
         mid();
         check("t2_rd_gnt",    64'(gnt_a[2]), 64'd1);
         check("t2_rd_rvalid", 64'(rvalid_a[2]), 64'd0);
         next_cycle();
      end
      soc_req = 1'b0;
      for (int i = 0; i < 3; i++) begin
         mid();
         check("t2_rvalid", 64'(rvalid_a[2]), 64'd1);
         check("t2_rdata",  dout_a[2], t2_data[i]);
         next_cycle();
      end
      mid();
      check("t2_rvalid_end", 64'(rvalid_a[2]), 64'd0);

      // Handover to accelerator with a read in flight, RD_LATENCY=2
      do_reset();
      soc_req = 1'b1; soc_we = 1'b1; soc_addr = 32'h0020; soc_din = 64'h55;
      next_cycle();
      soc_we = 1'b0;
      mid();
      check("t3_rd_gnt", 64'(gnt_a[1]), 64'd1);
      next_cycle();
      soc_req = 1'b0; acc_req = 1'b1;
      mid();
      check("t3_t1_acc_gnt", 64'(acc_gnt_a[1]), 64'd0);
      check("t3_t1_rvalid",  64'(rvalid_a[1]), 64'd0);
      next_cycle();
      soc_req = 1'b1; soc_addr = 32'h0030;
      mid();
      check("t3_rvalid",     64'(rvalid_a[1]), 64'd1);
      check("t3_rdata",      dout_a[1], 64'h55);
      check("t3_t2_gnt",     64'(gnt_a[1]), 64'd0);
      check("t3_t2_err",     64'(err_a[1]), 64'd0);
      check("t3_t2_acc_gnt", 64'(acc_gnt_a[1]), 64'd0);
      check("t3_t2_stall",   64'(stall_a[1]), 64'd0);
      next_cycle();
      mid();
      check("t3_t3_gnt",     64'(gnt_a[1]), 64'd0);
      check("t3_t3_acc_gnt", 64'(acc_gnt_a[1]), 64'd0);
      next_cycle();
      mid();
      check("t3_t4_acc_gnt", 64'(acc_gnt_a[1]), 64'd1);
      check("t3_t4_gnt",     64'(gnt_a[1]), 64'd0);
      next_cycle();

      // Accelerator writes banks 0 and 2, then hands back to the SoC
      soc_req  = 1'b0;
      acc_we   = 4'b0101;
      acc_addr = {12'h044, 12'h033, 12'h022, 12'h011};
      acc_wdata = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                   64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
      mid();
      check("t3_stall",      64'(stall_a[1]), 64'd3);
      check("t3_t5_err",     64'(err_a[1]), 64'd0);
      check("t4_bank_we",    64'(bank_we_a[1]), 64'b0101);
      check("t4_addr_b0",    64'(bank_addr_a[1][0 +: AW]), 64'h011);
      check("t4_addr_b2",    64'(bank_addr_a[1][2*AW +: AW]), 64'h033);
      check("t4_wdata_b0",   bank_wdata_a[1][0 +: WIDTH], 64'h1111_1111_1111_1111);
      check("t4_wdata_b1",   bank_wdata_a[1][WIDTH +: WIDTH], 64'h2222_2222_2222_2222);
      check("t4_wdata_b2",   bank_wdata_a[1][2*WIDTH +: WIDTH], 64'h3333_3333_3333_3333);
      next_cycle();
      acc_req = 1'b0; soc_req = 1'b1; soc_we = 1'b0; soc_addr = 32'h0011;
      mid();
      check("t4_d0_acc_gnt", 64'(acc_gnt_a[1]), 64'd1);
      check("t4_d0_gnt",     64'(gnt_a[1]), 64'd0);
      next_cycle();
      mid();
      check("t4_d1_acc_gnt", 64'(acc_gnt_a[1]), 64'd0);
      check("t4_d1_gnt",     64'(gnt_a[1]), 64'd0);
      check("t4_d1_we",      64'(bank_we_a[1]), 64'd0);
      check("t4_d1_addr_b2", 64'(bank_addr_a[1][2*AW +: AW]), 64'h033);
      next_cycle();
      mid();
      check("t4_d2_gnt", 64'(gnt_a[1]), 64'd0);
      check("t4_d2_we",  64'(bank_we_a[1]), 64'd0);
      next_cycle();
      mid();
      check("t4_d3_gnt",     64'(gnt_a[1]), 64'd1);
      check("t4_d3_we",      64'(bank_we_a[1]), 64'd0);
      check("t4_d3_addr_b0", 64'(bank_addr_a[1][0 +: AW]), 64'h011);
      next_cycle();
      soc_req = 1'b0; acc_we = '0;
      mid();
      check("t4_stall", 64'(stall_a[1]), 64'd6);
      next_cycle();
      mid();
      check("t4_rvalid", 64'(rvalid_a[1]), 64'd1);
      check("t4_rdata",  dout_a[1], 64'h1111_1111_1111_1111);
      next_cycle();

      // Out-of-range access, RD_LATENCY=1
      do_reset();
      soc_req = 1'b1; soc_we = 1'b0; soc_addr = 32'h4000;
      mid();
      check("t5_gnt",     64'(gnt_a[0]), 64'd0);
      check("t5_we",      64'(bank_we_a[0]), 64'd0);
      check("t5_addr",    64'(bank_addr_a[0]), 64'd0);
      check("t5_err_e0",  64'(err_a[0]), 64'd0);
      next_cycle();
      soc_req = 1'b0;
      mid();
      check("t5_err_e1",  64'(err_a[0]), 64'd1);
      next_cycle();
      mid();
      check("t5_err_e2",  64'(err_a[0]), 64'd0);
      check("t5_stall",   64'(stall_a[0]), 64'd0);
      next_cycle();
      acc_req = 1'b1;
      w = 0;
      while (!acc_gnt_a[0] && w < 8) begin
         next_cycle();
         w++;
      end
      check("t5_acc_gnt",     64'(acc_gnt_a[0]), 64'd1);
      check("t5_acc_latency", 64'(w), 64'd2);
      soc_req = 1'b1; soc_addr = 32'h4000;
      for (int i = 0; i < 2; i++) begin
         mid();
         check("t5_acc_gnt0", 64'(gnt_a[0]), 64'd0);
         check("t5_acc_err",  64'(err_a[0]), 64'd0);
         next_cycle();
      end
      soc_req = 1'b0;
      mid();
      check("t5_acc_err_end", 64'(err_a[0]), 64'd0);
      check("t5_acc_stall",   64'(stall_a[0]), 64'd0);
      next_cycle();

      // Stall counter saturation, then reset in the middle of a drain
      soc_req = 1'b1; soc_we = 1'b0; soc_addr = 32'h0100;
      repeat (70000) next_cycle();
      mid();
      check("t6_stall_sat", 64'(stall_a[0]), 64'hFFFF);
      check("t6_stall_sat2", 64'(stall_a[2]), 64'hFFFF);
      next_cycle();
      acc_req   = 1'b0;
      acc_addr  = {12'h044, 12'h033, 12'h022, 12'h011};
      acc_wdata = {4{64'h5A5A_5A5A_5A5A_5A5A}};
      next_cycle();
      #1;
      check("t6_drain_addr",    64'(bank_addr_a[2][0 +: AW]), 64'h011);
      check("t6_drain_acc_gnt", 64'(acc_gnt_a[2]), 64'd0);
      rst_n = 1'b0;
      #1;
      check("t6_rst_acc_gnt", 64'(acc_gnt_a[2]), 64'd0);
      check("t6_rst_we",      64'(bank_we_a[2]), 64'd0);
      check("t6_rst_addr",    64'(bank_addr_a[2]), 64'd0);
      check("t6_rst_wdata",   bank_wdata_a[2][0 +: WIDTH], 64'd0);
      check("t6_rst_rdata",   acc_rdata_a[2][0 +: WIDTH], 64'd0);
      check("t6_rst_gnt",     64'(gnt_a[2]), 64'd0);
      check("t6_rst_rvalid",  64'(rvalid_a[2]), 64'd0);
      check("t6_rst_dout",    dout_a[2], 64'd0);
      check("t6_rst_err",     64'(err_a[2]), 64'd0);
      check("t6_rst_stall",   64'(stall_a[2]), 64'd0);
      next_cycle();
      rst_n = 1'b1;
      mid();
      check("t6_post_gnt",     64'(gnt_a[2]), 64'd1);
      check("t6_post_acc_gnt", 64'(acc_gnt_a[2]), 64'd0);
      next_cycle();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
